branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Consumes the 3-bit one-hot compare code produced by the ALU set-less-than comparator: bit0 equal, bit1 greater, bit2 less (signed a vs b).
- Combines the code with a branch opcode, the PC and an offset.
- Produces a registered taken/target decision and a timed flush pulse for the fetch/decode stages.
- Sits at the EX/MEM boundary of the CPU pipeline and holds one registered output slot with a valid/ready handshake.

Parameters:
- PC_W, 32, width of pc, imm and target.
- FLUSH_CYCLES, 2, number of consecutive cycles flush is held high after a taken branch is accepted (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a branch candidate
- in_ready  out  1  block accepts the candidate this cycle
- cmp_code  in  3  {less, greater, equal} from the comparator
- br_op  in  3  000 NONE, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BGT, 110 BLE, 111 JMP
- pc  in  PC_W  address of the branch instruction
- imm  in  PC_W  sign-extended word offset
- out_valid  out  1  registered decision is valid
- out_ready  in  1  downstream consumes the decision
- taken  out  1  branch is taken
- target  out  PC_W  next PC
- flush  out  1  squash younger instructions
- cmp_err  out  1  cmp_code was not one-hot on a conditional op; qualified by out_valid

Behaviour:
- Reset: out_valid, taken, flush, cmp_err = 0; target = 0; state = RUN; flush counter = 0.
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Accept condition: accept = in_valid && in_ready.
- in_ready rule: in_ready = (state == RUN) && (!out_valid || out_ready). This is combinational from registers and out_ready.
- Condition evaluation on the accept cycle, with e/g/l taken from cmp_code:
  - BEQ = e; BNE = !e; BLT = l; BGE = e|g; BGT = g; BLE = e|l.
  - JMP = 1; NONE = 0.
- Illegal compare code: for a conditional op (001..110), cmp_code not exactly one-hot forces taken = 0 and cmp_err = 1. For NONE and JMP, cmp_err = 0 regardless of cmp_code.
- Target arithmetic: taken gives target = pc + 4 + (imm << 2); not taken gives target = pc + 4. All arithmetic is modulo 2^PC_W, with no overflow flag.
- Latency: a decision is registered one cycle after accept. out_valid stays high until out_valid && out_ready, and the held outputs are stable while stalled.
- Back-to-back: if out_ready is high, a new accept in the same cycle replaces the slot (full throughput).
- States:
  - RUN: normal operation. An accept with a taken result moves to FLUSH.
  - FLUSH: entered on the cycle after a taken accept. flush = 1 for exactly FLUSH_CYCLES cycles; the first flush cycle coincides with the first out_valid cycle of that decision. in_ready = 0 throughout, and in_valid is ignored. The counter decrements each cycle; at 1 the block returns to RUN.
- The flush count is independent of out_ready. A decision still stalled when FLUSH ends keeps in_ready low via the !out_valid term.
- rst asserted mid-FLUSH or mid-stall: all state clears next edge; no residual flush pulse.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined: adds ports br_cnt (out, 16) and tkn_cnt (out, 16). br_cnt counts accepts with br_op != NONE; tkn_cnt counts accepts with taken = 1. Both saturate at 16'hFFFF, clear on rst, and update on the same edge as the decision register.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cpu_br_pkg:
  - br_op encodings (BR_NONE .. BR_JMP)
  - cmp_code bit indices (CMP_EQ = 0, CMP_GT = 1, CMP_LT = 2)
  - state enum (ST_RUN, ST_FLUSH)
- One combinational sub-module, br_cond_decode, maps (br_op, cmp_code) to (cond_true, code_err).
- Registers, FSM, target adder and counters stay in branch_resolve.

Test Plan:
- Reset with in_valid = 1 -> out_valid = 0, flush = 0, target = 0 the cycle after rst drops; in_ready = 1.
- BEQ, cmp_code = 3'b001, pc = 0x100, imm = 0x4, out_ready = 1 -> next cycle out_valid = 1, taken = 1, target = 0x114; flush high 2 cycles; in_ready low 2 cycles.
- BLT, cmp_code = 3'b010 (greater), pc = 0x200 -> taken = 0, target = 0x204, flush never asserts. Back-to-back accepts on consecutive cycles each produce one decision.
- BGE, cmp_code = 3'b011 (illegal) -> taken = 0, cmp_err = 1, target = pc + 4. Same code with JMP, imm = 0xFFFFFFFF, pc = 0x0 -> taken = 1, target = 0x0, cmp_err = 0.
- Stall: decision held with out_ready = 0 for 5 cycles -> outputs constant, in_ready = 0. out_ready = 1 -> handshake completes, in_ready = 1 the same cycle.
- rst asserted during the 2nd flush cycle -> flush = 0 and out_valid = 0 next cycle. With BR_STATS_EN: 3 branches, 2 taken -> br_cnt = 3, tkn_cnt = 2; rst clears both to 0.

Source files
------------

// File: rtl/cpu_br_pkg.sv
// -----------------------------------------------------------------------------
// cpu_br_pkg
// Shared encodings for the branch resolution block:
//   - branch opcode encodings (BR_NONE .. BR_JMP)
//   - bit positions inside the comparator's one-hot compare code
//   - the flush sequencer state enum
//   - a small one-hot helper used by the condition decoder
// -----------------------------------------------------------------------------
package cpu_br_pkg;

    // Branch opcodes as presented by the decode stage
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_BGT  = 3'b101;
    localparam logic [2:0] BR_BLE  = 3'b110;
    localparam logic [2:0] BR_JMP  = 3'b111;

    // Bit indices of the comparator output {less, greater, equal}
    localparam int CMP_EQ = 0;
    localparam int CMP_GT = 1;
    localparam int CMP_LT = 2;

    // Flush sequencer states
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // A well-formed compare code has exactly one bit set
    function automatic logic is_onehot3(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

endpackage

// File: rtl/br_cond_decode.sv
// -----------------------------------------------------------------------------
// br_cond_decode
// Purely combinational: maps a branch opcode and the comparator's one-hot
// compare code to a branch condition and a malformed-code error flag.
//
// Ports:
//   i_br_op      in  3  branch opcode (see cpu_br_pkg)
//   i_cmp_code   in  3  {less, greater, equal} from the comparator
//   o_cond_true  out 1  branch condition holds (forced 0 on a malformed code)
//   o_code_err   out 1  conditional op seen with a non-one-hot compare code
// -----------------------------------------------------------------------------
module br_cond_decode
    import cpu_br_pkg::*;
(
    input  logic [2:0] i_br_op,
    input  logic [2:0] i_cmp_code,
    output logic       o_cond_true,
    output logic       o_code_err
);

    logic w_eq;
    logic w_gt;
    logic w_lt;
    logic w_legal;
    logic w_cond;
    logic w_is_conditional;

    assign w_eq    = i_cmp_code[CMP_EQ];
    assign w_gt    = i_cmp_code[CMP_GT];
    assign w_lt    = i_cmp_code[CMP_LT];
    assign w_legal = is_onehot3(i_cmp_code);

    always_comb begin
        w_cond           = 1'b0;
        w_is_conditional = 1'b0;
        case (i_br_op)
            BR_NONE: begin
                w_cond = 1'b0;
            end
            BR_BEQ: begin
                w_cond           = w_eq;
                w_is_conditional = 1'b1;
            end
            BR_BNE: begin
                w_cond           = !w_eq;
                w_is_conditional = 1'b1;
            end
            BR_BLT: begin
                w_cond           = w_lt;
                w_is_conditional = 1'b1;
            end
            BR_BGE: begin
                w_cond           = w_eq | w_gt;
                w_is_conditional = 1'b1;
            end
            BR_BGT: begin
                w_cond           = w_gt;
                w_is_conditional = 1'b1;
            end
            BR_BLE: begin
                w_cond           = w_eq | w_lt;
                w_is_conditional = 1'b1;
            end
            default: begin  // BR_JMP: unconditional, compare code irrelevant
                w_cond = 1'b1;
            end
        endcase
    end

    // A malformed compare code can never produce a taken conditional branch;
    // NONE and JMP ignore the code entirely.
    assign o_cond_true = w_is_conditional ? (w_cond && w_legal) : w_cond;
    assign o_code_err  = w_is_conditional && !w_legal;

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// EX/MEM branch resolution. Accepts a branch candidate (opcode, compare code,
// PC, word offset), registers a taken/target decision in a single output slot
// with a valid/ready handshake, and issues a flush pulse of FLUSH_CYCLES
// cycles for the fetch/decode stages whenever a taken branch is accepted.
//
// Optional feature: define BR_STATS_EN to add saturating 16-bit counters of
// accepted branches (br_cnt) and accepted taken branches (tkn_cnt).
//
// Ports:
//   clk        in  1     rising-edge clock
//   rst        in  1     synchronous, active-high reset
//   in_valid   in  1     upstream holds a branch candidate
//   in_ready   out 1     candidate accepted this cycle when in_valid is high
//   cmp_code   in  3     {less, greater, equal} from the comparator
//   br_op      in  3     branch opcode (see cpu_br_pkg)
//   pc         in  PC_W  address of the branch instruction
//   imm        in  PC_W  sign-extended word offset
//   out_valid  out 1     registered decision is valid
//   out_ready  in  1     downstream consumes the decision
//   taken      out 1     branch is taken
//   target     out PC_W  next PC
//   flush      out 1     squash younger instructions
//   cmp_err    out 1     malformed compare code on a conditional op
//   br_cnt     out 16    (BR_STATS_EN) accepted branches with op != NONE
//   tkn_cnt    out 16    (BR_STATS_EN) accepted taken branches
//   dbg_state  out 1     current sequencer state (0 = RUN, 1 = FLUSH)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and its payload stable until that edge;
// ready may depend combinationally on the consumer's ready but never on valid.
// -----------------------------------------------------------------------------
module branch_resolve
    import cpu_br_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      cmp_code,
    input  logic [2:0]      br_op,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [PC_W-1:0] target,
    output logic            flush,
    output logic            cmp_err,
`ifdef BR_STATS_EN
    output logic [15:0]     br_cnt,
    output logic [15:0]     tkn_cnt,
`endif
    output logic            dbg_state
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t          r_state;
    logic [3:0]      r_flush_cnt;
    logic            r_flush;
    logic            r_out_valid;
    logic            r_taken;
    logic [PC_W-1:0] r_target;
    logic            r_cmp_err;

    logic            w_cond_true;
    logic            w_code_err;
    logic            w_accept;
    logic            w_in_ready;
    logic [PC_W-1:0] w_tgt_seq;
    logic [PC_W-1:0] w_tgt_br;

    br_cond_decode u_cond (
        .i_br_op     (br_op),
        .i_cmp_code  (cmp_code),
        .o_cond_true (w_cond_true),
        .o_code_err  (w_code_err)
    );

    // The slot can take a new candidate when empty or when its current
    // occupant leaves on this same edge; the flush window blocks all accepts.
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // Wrap-around arithmetic; imm is a word offset, hence the shift.
    assign w_tgt_seq = pc + PC_W'(4);
    assign w_tgt_br  = w_tgt_seq + (imm << 2);

    // Decision slot and flush sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
            r_flush     <= 1'b0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_cmp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_taken     <= w_cond_true;
                r_target    <= w_cond_true ? w_tgt_br : w_tgt_seq;
                r_cmp_err   <= w_code_err;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    // Flush starts together with the decision's first valid cycle
                    if (w_accept && w_cond_true) begin
                        r_state     <= ST_FLUSH;
                        r_flush     <= 1'b1;
                        r_flush_cnt <= FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    // Counter holds the number of flush cycles still to show,
                    // including the current one; independent of out_ready.
                    if (r_flush_cnt <= 4'd1) begin
                        r_state     <= ST_RUN;
                        r_flush     <= 1'b0;
                        r_flush_cnt <= 4'd0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_flush     <= 1'b0;
                    r_flush_cnt <= 4'd0;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    logic [15:0] r_br_cnt;
    logic [15:0] r_tkn_cnt;

    // Saturating statistics, updated on the same edge as the decision slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt  <= 16'd0;
            r_tkn_cnt <= 16'd0;
        end else if (w_accept) begin
            if ((br_op != BR_NONE) && (r_br_cnt != 16'hFFFF)) begin
                r_br_cnt <= r_br_cnt + 16'd1;
            end
            if (w_cond_true && (r_tkn_cnt != 16'hFFFF)) begin
                r_tkn_cnt <= r_tkn_cnt + 16'd1;
            end
        end
    end

    assign br_cnt  = r_br_cnt;
    assign tkn_cnt = r_tkn_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign taken     = r_taken;
    assign target    = r_target;
    assign flush     = r_flush;
    assign cmp_err   = r_cmp_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Self-checking bench for branch_resolve. A reference model derived from the
// branch rules predicts every decision, the flush window and the ready signal;
// a scoreboard queue decouples stimulus from the output monitor.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int PC_W = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      cmp_code = 3'b000;
    logic [2:0]      br_op = 3'b000;
    logic [PC_W-1:0] pc = '0;
    logic [PC_W-1:0] imm = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            flush;
    logic            cmp_err;
    logic            dbg_state;
`ifdef BR_STATS_EN
    logic [15:0]     br_cnt;
    logic [15:0]     tkn_cnt;
`endif

    branch_resolve #(.PC_W(PC_W), .FLUSH_CYCLES(FC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmp_code  (cmp_code),
        .br_op     (br_op),
        .pc        (pc),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .target    (target),
        .flush     (flush),
        .cmp_err   (cmp_err),
`ifdef BR_STATS_EN
        .br_cnt    (br_cnt),
        .tkn_cnt   (tkn_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    // {taken, target, cmp_err}
    logic [PC_W+1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [PC_W+1:0] ref_eval(input logic [2:0] op, input logic [2:0] code,
                                                 input logic [PC_W-1:0] p, input logic [PC_W-1:0] i);
        logic e, g, l, c, err, legal;
        logic [PC_W-1:0] tgt;
        e = code[0];
        g = code[1];
        l = code[2];
        legal = ($countones(code) == 1);
        err = 1'b0;
        case (op)
            3'd0:    c = 1'b0;
            3'd1:    c = e;
            3'd2:    c = !e;
            3'd3:    c = l;
            3'd4:    c = e | g;
            3'd5:    c = g;
            3'd6:    c = e | l;
            default: c = 1'b1;
        endcase
        if (op >= 3'd1 && op <= 3'd6 && !legal) begin
            c = 1'b0;
            err = 1'b1;
        end
        tgt = c ? (p + 32'd4 + i * 32'd4) : (p + 32'd4);
        return {c, tgt, err};
    endfunction

    // Cycle model: predicts out_valid, flush, in_ready and state each cycle and
    // pushes the expected decision for every accept.
    int  flush_left = 0;
    bit  slot_full = 1'b0;
    int  exp_br = 0;
    int  exp_tkn = 0;

    initial begin
        logic exp_rdy;
        logic [PC_W+1:0] r;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("out_valid", out_valid, slot_full);
            check("flush", flush, flush_left > 0);
            check("state", dbg_state, flush_left > 0);
            exp_rdy = (flush_left == 0) && (!slot_full || out_ready);
            check("in_ready", in_ready, exp_rdy);
`ifdef BR_STATS_EN
            check("br_cnt", br_cnt, exp_br);
            check("tkn_cnt", tkn_cnt, exp_tkn);
`endif
            if (rst) begin
                slot_full = 1'b0;
                flush_left = 0;
                exp_q.delete();
                exp_br = 0;
                exp_tkn = 0;
            end else begin
                if (flush_left > 0) flush_left--;
                if (in_valid && exp_rdy) begin
                    r = ref_eval(br_op, cmp_code, pc, imm);
                    exp_q.push_back(r);
                    slot_full = 1'b1;
                    if (r[PC_W+1]) flush_left = FC;
                    if (br_op != 3'd0 && exp_br < 65535) exp_br++;
                    if (r[PC_W+1] && exp_tkn < 65535) exp_tkn++;
                end else if (slot_full && out_ready) begin
                    slot_full = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [PC_W+1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got output target %0h with no expected entry", target);
            end else begin
                e = exp_q.pop_front();
                check("sb_taken", taken, e[PC_W+1]);
                check("sb_target", target, e[PC_W:1]);
                check("sb_cmp_err", cmp_err, e[0]);
            end
        end
    end

    // ---------------- out_ready driver ----------------
    bit rand_rdy = 1'b0;
    bit force_rdy = 1'b1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [2:0] code,
                        input logic [PC_W-1:0] p, input logic [PC_W-1:0] i);
        int n;
        n = 0;
        in_valid = 1'b1;
        br_op = op;
        cmp_code = code;
        pc = p;
        imm = i;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_ready && !rst) && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset with a candidate already presented
        rst = 1'b1;
        in_valid = 1'b1;
        br_op = 3'd0;
        cmp_code = 3'b000;
        pc = 32'h40;
        imm = '0;
        force_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_target", target, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(2);

        // Taken BEQ: two flush cycles, ready low throughout
        send(3'd1, 3'b001, 32'h100, 32'h4);
        @(negedge clk);
        check("beq_valid", out_valid, 1'b1);
        check("beq_taken", taken, 1'b1);
        check("beq_target", target, 32'h114);
        check("beq_flush1", flush, 1'b1);
        check("beq_rdy1", in_ready, 1'b0);
        @(negedge clk);
        check("beq_flush2", flush, 1'b1);
        check("beq_rdy2", in_ready, 1'b0);
        @(negedge clk);
        check("beq_flush_end", flush, 1'b0);
        check("beq_rdy_back", in_ready, 1'b1);
        idle(1);

        // Not-taken branches, back to back
        send(3'd3, 3'b010, 32'h200, 32'h10);
        send(3'd5, 3'b100, 32'h300, 32'h20);
        send(3'd1, 3'b010, 32'h400, 32'h30);
        @(negedge clk);
        check("nt_flush", flush, 1'b0);
        idle(2);

        // Malformed code on a conditional op, then on JMP with wrap-around
        send(3'd4, 3'b011, 32'h500, 32'h7);
        @(negedge clk);
        check("bge_taken", taken, 1'b0);
        check("bge_err", cmp_err, 1'b1);
        check("bge_target", target, 32'h504);
        idle(1);
        send(3'd7, 3'b011, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("jmp_taken", taken, 1'b1);
        check("jmp_target", target, 32'h0);
        check("jmp_err", cmp_err, 1'b0);
        idle(4);

        // Stall: decision held for 5 cycles, then released
        @(negedge clk);
        force_rdy = 1'b0;
        idle(2);
        send(3'd3, 3'b010, 32'h200, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_taken", taken, 1'b0);
            check("stall_target", target, 32'h204);
            check("stall_rdy", in_ready, 1'b0);
        end
        force_rdy = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        check("release_valid", out_valid, 1'b1);
        check("release_rdy", in_ready, 1'b1);
        idle(2);

        // Reset during the second flush cycle
        send(3'd1, 3'b001, 32'h600, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_flush", flush, 1'b0);
        check("midrst_valid", out_valid, 1'b0);
        idle(2);

`ifdef BR_STATS_EN
        // Three branches, two taken
        send(3'd1, 3'b001, 32'h700, 32'h2);
        idle(3);
        send(3'd2, 3'b001, 32'h800, 32'h2);
        send(3'd7, 3'b000, 32'h900, 32'h2);
        idle(4);
        @(negedge clk);
        check("stats_br", br_cnt, 16'd3);
        check("stats_tkn", tkn_cnt, 16'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("stats_br_rst", br_cnt, 16'd0);
        check("stats_tkn_rst", tkn_cnt, 16'd0);
        idle(1);
`endif

        // Randomized traffic with random downstream back-pressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        force_rdy = 1'b1;
        idle(20);
        check("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
